uart_tx_scheduler: RTL and testbench
====================================

UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

Interface
REQ-001 Parameters SHALL be: NREQ, default 4, number of byte-stream requesters; BAUD_DIV, default 16'd868, baud divisor written at configuration; CTRL_VAL, default 32'h3, control word enabling TX and RX; TIMEOUT, default 255, mid-packet stall limit in cycles.
REQ-002 clk_i input 1: the single clock; all state SHALL update on its rising edge.
REQ-003 rst_i input 1: reset, synchronous and active-high.
REQ-004 req_valid_i input NREQ: requester byte valid.
REQ-005 req_data_i input NREQ*8: requester bytes; requester k occupies bits [8k+7:8k].
REQ-006 req_last_i input NREQ: marks the final byte of a packet.
REQ-007 req_ready_o output NREQ: byte accepted this cycle.
REQ-008 tx_full_i input 1: UART core TX FIFO full.
REQ-009 reg_we_o output 1: register write strobe to the UART core.
REQ-010 reg_re_o output 1: register read strobe to the UART core; SHALL be tied to 0.
REQ-011 reg_addr_o output 12: register address.
REQ-012 reg_wdata_o output 32: register write data.
REQ-013 grant_o output NREQ: one-hot current owner, or all zeros.
REQ-014 cfg_done_o output 1: configuration sequence complete.
REQ-015 busy_o output 1: a packet is in progress.
REQ-016 abort_o output 1: one-cycle pulse on timeout release.

Function
REQ-017 FSM states SHALL be CFG_BAUD, CFG_CTRL, IDLE and SEND.
REQ-018 CFG_BAUD SHALL drive reg_we_o=1, reg_addr_o=ADDR_BAUD and reg_wdata_o={16'h0,BAUD_DIV} for exactly one cycle, then go to CFG_CTRL.
REQ-019 CFG_CTRL SHALL drive reg_we_o=1, reg_addr_o=ADDR_CTRL and reg_wdata_o=CTRL_VAL for one cycle, then go to IDLE and set cfg_done_o=1, which stays set until reset.
REQ-020 In IDLE, if any req_valid_i bit is set, the FSM SHALL grant the first valid requester searching round-robin from last_grant+1 mod NREQ.
REQ-021 The grant SHALL be registered and SEND entered on the next cycle; no byte is accepted in the grant cycle.
REQ-022 In SEND, when req_valid_i[g]=1 and tx_full_i=0, the block SHALL, in the same cycle, assert req_ready_o[g]=1, reg_we_o=1, reg_addr_o=ADDR_TXDATA and reg_wdata_o={24'h0,byte_g}.
REQ-023 Throughput in SEND SHALL be one byte per cycle while the requester is valid and the TX FIFO is not full.
REQ-024 When tx_full_i=1, the block SHALL stall: no ready, no write, grant held; the stall timer SHALL NOT advance.
REQ-025 An accepted byte with req_last_i[g]=1 SHALL end the packet: last_grant←g, return to IDLE, and re-arbitrate on the following cycle.
REQ-026 In SEND with req_valid_i[g]=0 and tx_full_i=0, the stall counter SHALL increment; it SHALL clear on any accepted byte.
REQ-027 When the stall counter reaches TIMEOUT, the block SHALL pulse abort_o for one cycle, set last_grant←g, return to IDLE, and clear grant_o.
REQ-028 Requests other than the granted requester SHALL be ignored mid-packet; at most one req_ready_o bit SHALL ever be set.
REQ-029 Requests arriving during CFG_BAUD or CFG_CTRL SHALL be held off (ready=0) until IDLE.
REQ-030 When no write is issued, reg_we_o, reg_addr_o and reg_wdata_o SHALL be 0.
REQ-031 busy_o SHALL equal (state==SEND).
REQ-032 A single-byte packet (valid and last together) SHALL complete in one SEND cycle.

Reset
REQ-033 rst_i=1 at any clock edge SHALL force state←CFG_BAUD, last_grant←NREQ-1, grant_o←0, stall counter←0, cfg_done_o←0 and abort_o←0, with all strobes 0 during reset.
REQ-034 Reset mid-packet SHALL drop the packet silently and rerun the configuration sequence.

Structure
REQ-035 Package uart_sched_pkg SHALL hold the state enum and ADDR_BAUD=12'h000, ADDR_CTRL=12'h004 and ADDR_TXDATA=12'h008.
REQ-036 One sub-module, rr_arbiter (NREQ-wide round-robin pick from a pointer), SHALL be instantiated; the remainder SHALL be flat.

Verification
REQ-037 Reset release -> cycle 1: write 0x000←0x364; cycle 2: write 0x004←0x3; cfg_done_o=1 from cycle 3.
REQ-038 Req0 and req2 both valid in IDLE after reset -> req0 granted and sends bytes 0xA1,0xA2 (last) on consecutive cycles; req2 granted next, then req0 again if pending.
REQ-039 tx_full_i high for 5 cycles mid-packet -> no writes, no ready, abort_o=0, grant held; transfer resumes the cycle after full drops.
REQ-040 Granted requester drops valid for 255 cycles -> abort_o pulses once, grant_o=0, next requester served.
REQ-041 rst_i asserted during SEND -> no further TXDATA writes; configuration sequence reissued after release.

Source files
------------

// File: rtl/uart_sched_pkg.sv
//==============================================================================
// Module      : uart_sched_pkg
// Description : Shared types and register map for the UART TX scheduler.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package uart_sched_pkg;

    // Scheduler states: two configuration writes, then arbitration and send.
    typedef enum logic [1:0] {
        CFG_BAUD = 2'd0,
        CFG_CTRL = 2'd1,
        IDLE     = 2'd2,
        SEND     = 2'd3
    } sched_state_t;

    // UART core register map.
    localparam logic [11:0] ADDR_BAUD   = 12'h000;
    localparam logic [11:0] ADDR_CTRL   = 12'h004;
    localparam logic [11:0] ADDR_TXDATA = 12'h008;

    // Width of an index into n requesters; never less than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
//==============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin pick. Searches requesters starting
//               at the slot after i_ptr, wrapping once, and returns the first
//               active one as both a one-hot vector and an index.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module rr_arbiter
    import uart_sched_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = idx_width(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_gnt_idx,
    output logic          o_any
);

    // Walk N slots from i_ptr+1 (mod N); the first requester seen wins.
    always_comb begin
        int w_slot;
        w_slot    = 0;
        o_gnt     = '0;
        o_gnt_idx = '0;
        o_any     = 1'b0;
        for (int i = 1; i <= N; i++) begin
            // i_ptr < N and i <= N, so a single subtraction wraps correctly.
            w_slot = int'(i_ptr) + i;
            if (w_slot >= N) begin
                w_slot = w_slot - N;
            end
            if (!o_any && i_req[w_slot]) begin
                o_any         = 1'b1;
                o_gnt[w_slot] = 1'b1;
                o_gnt_idx     = IW'(w_slot);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_tx_scheduler.sv
//==============================================================================
// Module      : uart_tx_scheduler
// Description : Configures a UART core (baud divisor, control word) out of
//               reset, then arbitrates byte streams from NREQ requesters
//               round-robin and forwards one packet at a time into the
//               core's TX data register. A granted requester that stalls
//               for TIMEOUT cycles loses the grant and abort_o pulses.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module uart_tx_scheduler
    import uart_sched_pkg::*;
#(
    parameter int          NREQ     = 4,
    parameter logic [15:0] BAUD_DIV = 16'd868,
    parameter logic [31:0] CTRL_VAL = 32'h3,
    parameter int          TIMEOUT  = 255
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NREQ-1:0]   req_valid_i,
    input  logic [NREQ*8-1:0] req_data_i,
    input  logic [NREQ-1:0]   req_last_i,
    output logic [NREQ-1:0]   req_ready_o,
    input  logic              tx_full_i,
    output logic              reg_we_o,
    output logic              reg_re_o,
    output logic [11:0]       reg_addr_o,
    output logic [31:0]       reg_wdata_o,
    output logic [NREQ-1:0]   grant_o,
    output logic              cfg_done_o,
    output logic              busy_o,
    output logic              abort_o
);

    localparam int            IW          = idx_width(NREQ);
    localparam int            SW          = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [IW-1:0] c_LAST_INIT = IW'(NREQ - 1);
    localparam logic [SW-1:0] c_TIMEOUT   = SW'(TIMEOUT);

    // Registered state
    sched_state_t     r_state;
    logic [NREQ-1:0]  r_grant;
    logic [IW-1:0]    r_owner;
    logic [IW-1:0]    r_last_grant;
    logic [SW-1:0]    r_stall;
    logic             r_cfg_done;
    logic             r_abort;

    // Next-state values
    sched_state_t     w_state_nxt;
    logic [NREQ-1:0]  w_grant_nxt;
    logic [IW-1:0]    w_owner_nxt;
    logic [IW-1:0]    w_last_grant_nxt;
    logic [SW-1:0]    w_stall_nxt;
    logic             w_cfg_done_nxt;
    logic             w_abort_nxt;

    // Arbiter results and the currently owned requester's lane
    logic [NREQ-1:0]  w_arb_gnt;
    logic [IW-1:0]    w_arb_idx;
    logic             w_arb_any;
    logic             w_sel_valid;
    logic             w_sel_last;
    logic [7:0]       w_sel_data;
    logic [SW-1:0]    w_stall_inc;

    rr_arbiter #(
        .N  (NREQ),
        .IW (IW)
    ) u_arb (
        .i_req     (req_valid_i),
        .i_ptr     (r_last_grant),
        .o_gnt     (w_arb_gnt),
        .o_gnt_idx (w_arb_idx),
        .o_any     (w_arb_any)
    );

    assign w_sel_valid = req_valid_i[r_owner];
    assign w_sel_last  = req_last_i[r_owner];
    assign w_sel_data  = req_data_i[{r_owner, 3'b000} +: 8];
    assign w_stall_inc = r_stall + SW'(1);

    // State register and all bookkeeping registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= CFG_BAUD;
            r_grant      <= '0;
            r_owner      <= '0;
            r_last_grant <= c_LAST_INIT;
            r_stall      <= '0;
            r_cfg_done   <= 1'b0;
            r_abort      <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_grant      <= w_grant_nxt;
            r_owner      <= w_owner_nxt;
            r_last_grant <= w_last_grant_nxt;
            r_stall      <= w_stall_nxt;
            r_cfg_done   <= w_cfg_done_nxt;
            r_abort      <= w_abort_nxt;
        end
    end

    // Next-state decode plus the register-bus and handshake outputs.
    always_comb begin
        w_state_nxt      = r_state;
        w_grant_nxt      = r_grant;
        w_owner_nxt      = r_owner;
        w_last_grant_nxt = r_last_grant;
        w_stall_nxt      = r_stall;
        w_cfg_done_nxt   = r_cfg_done;
        w_abort_nxt      = 1'b0;
        reg_we_o         = 1'b0;
        reg_addr_o       = '0;
        reg_wdata_o      = '0;
        req_ready_o      = '0;

        case (r_state)
            CFG_BAUD: begin
                reg_we_o    = 1'b1;
                reg_addr_o  = ADDR_BAUD;
                reg_wdata_o = {16'h0, BAUD_DIV};
                w_state_nxt = CFG_CTRL;
            end

            CFG_CTRL: begin
                reg_we_o       = 1'b1;
                reg_addr_o     = ADDR_CTRL;
                reg_wdata_o    = CTRL_VAL;
                w_state_nxt    = IDLE;
                w_cfg_done_nxt = 1'b1;
            end

            IDLE: begin
                // Grant is registered here; the first byte moves next cycle.
                if (w_arb_any) begin
                    w_grant_nxt = w_arb_gnt;
                    w_owner_nxt = w_arb_idx;
                    w_stall_nxt = '0;
                    w_state_nxt = SEND;
                end
            end

            SEND: begin
                // A full TX FIFO freezes everything, including the stall timer.
                if (!tx_full_i) begin
                    if (w_sel_valid) begin
                        req_ready_o = r_grant;
                        reg_we_o    = 1'b1;
                        reg_addr_o  = ADDR_TXDATA;
                        reg_wdata_o = {24'h0, w_sel_data};
                        w_stall_nxt = '0;
                        if (w_sel_last) begin
                            w_last_grant_nxt = r_owner;
                            w_grant_nxt      = '0;
                            w_state_nxt      = IDLE;
                        end
                    end else if (w_stall_inc == c_TIMEOUT) begin
                        // Owner went quiet too long: release it and move on.
                        w_abort_nxt      = 1'b1;
                        w_last_grant_nxt = r_owner;
                        w_grant_nxt      = '0;
                        w_stall_nxt      = '0;
                        w_state_nxt      = IDLE;
                    end else begin
                        w_stall_nxt = w_stall_inc;
                    end
                end
            end

            default: begin
                w_state_nxt = CFG_BAUD;
            end
        endcase

        // Strobes stay quiet for the whole of reset.
        if (rst_i) begin
            reg_we_o    = 1'b0;
            reg_addr_o  = '0;
            reg_wdata_o = '0;
            req_ready_o = '0;
        end
    end

    assign reg_re_o   = 1'b0;
    assign grant_o    = r_grant;
    assign cfg_done_o = r_cfg_done;
    assign busy_o     = (r_state == SEND);
    assign abort_o    = r_abort;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_scheduler.sv
//==============================================================================
// Module      : tb_uart_tx_scheduler
// Description : Self-checking bench for uart_tx_scheduler.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_uart_tx_scheduler;

    localparam int          N    = 4;
    localparam logic [15:0] BAUD = 16'd868;
    localparam logic [31:0] CTRL = 32'h3;
    localparam int          TMO  = 255;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req_valid;
    logic [N*8-1:0] req_data;
    logic [N-1:0]  req_last;
    logic [N-1:0]  req_ready;
    logic          tx_full;
    logic          reg_we;
    logic          reg_re;
    logic [11:0]   reg_addr;
    logic [31:0]   reg_wdata;
    logic [N-1:0]  grant;
    logic          cfg_done;
    logic          busy;
    logic          abort_p;

    int n_vec = 0;
    int n_err = 0;

    // Reference state: cfg step (0 baud, 1 ctrl, 2 done), owner (-1 none),
    // last served requester, idle-cycle count, abort due this cycle.
    int m_cfg, m_owner, m_last, m_stall;
    bit m_abort;

    always #5 clk = ~clk;

    uart_tx_scheduler #(
        .NREQ     (N),
        .BAUD_DIV (BAUD),
        .CTRL_VAL (CTRL),
        .TIMEOUT  (TMO)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_data_i  (req_data),
        .req_last_i  (req_last),
        .req_ready_o (req_ready),
        .tx_full_i   (tx_full),
        .reg_we_o    (reg_we),
        .reg_re_o    (reg_re),
        .reg_addr_o  (reg_addr),
        .reg_wdata_o (reg_wdata),
        .grant_o     (grant),
        .cfg_done_o  (cfg_done),
        .busy_o      (busy),
        .abort_o     (abort_p)
    );

    typedef struct {
        logic        rst;
        logic [3:0]  v;
        logic [31:0] d;
        logic [3:0]  l;
        logic        f;
        logic [56:0] e;
    } vec_t;

    vec_t tbl[11];

    // Output bundle: {we, re, addr, wdata, ready, grant, done, busy, abort}
    function automatic logic [56:0] mk(input logic we, input logic [11:0] a,
                                       input logic [31:0] d, input logic [3:0] r,
                                       input logic [3:0] g, input logic dn,
                                       input logic bz, input logic ab);
        return {we, 1'b0, a, d, r, g, dn, bz, ab};
    endfunction

    function automatic int pick(input logic [3:0] v, input int last);
        for (int i = 1; i <= N; i++) begin
            if (v[(last + i) % N]) return (last + i) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_cfg = 0; m_owner = -1; m_last = N - 1; m_stall = 0; m_abort = 1'b0;
    endtask

    // One clock cycle: drive, check mid-cycle, advance the reference model.
    task automatic cycle(input logic rst_v, input logic [3:0] v, input logic [31:0] d,
                         input logic [3:0] l, input logic f, input bit use_tbl,
                         input logic [56:0] texp, input string tag);
        logic [56:0] exp, act;
        logic        we_e;
        logic [11:0] a_e;
        logic [31:0] d_e;
        logic [3:0]  r_e, g_e;
        int          n_cfg, n_owner, n_last, n_stall;
        bit          n_abort;

        rst = rst_v; req_valid = v; req_data = d; req_last = l; tx_full = f;
        #4;

        n_cfg = m_cfg; n_owner = m_owner; n_last = m_last; n_stall = m_stall;
        n_abort = 1'b0;
        we_e = 1'b0; a_e = '0; d_e = '0; r_e = '0;
        g_e = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;

        if (rst_v) begin
            n_cfg = 0; n_owner = -1; n_last = N - 1; n_stall = 0;
        end else if (m_cfg == 0) begin
            we_e = 1'b1; a_e = 12'h000; d_e = {16'h0, BAUD}; n_cfg = 1;
        end else if (m_cfg == 1) begin
            we_e = 1'b1; a_e = 12'h004; d_e = CTRL; n_cfg = 2;
        end else if (m_owner < 0) begin
            n_owner = pick(v, m_last);
        end else if (!f) begin
            if (v[m_owner]) begin
                r_e = g_e; we_e = 1'b1; a_e = 12'h008;
                d_e = {24'h0, d[8*m_owner +: 8]};
                n_stall = 0;
                if (l[m_owner]) begin
                    n_owner = -1; n_last = m_owner;
                end
            end else begin
                n_stall = m_stall + 1;
                if (n_stall == TMO) begin
                    n_abort = 1'b1; n_owner = -1; n_last = m_owner; n_stall = 0;
                end
            end
        end

        exp = {we_e, 1'b0, a_e, d_e, r_e, g_e, (m_cfg == 2), (m_owner >= 0), m_abort};
        if (use_tbl) exp = texp;
        act = {reg_we, reg_re, reg_addr, reg_wdata, req_ready, grant, cfg_done, busy, abort_p};

        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h (we,re,addr,wdata,ready,grant,done,busy,abort)",
                     tag, act, exp);
        end

        @(posedge clk);
        m_cfg = n_cfg; m_owner = n_owner; m_last = n_last; m_stall = n_stall;
        m_abort = n_abort;
        #1;
    endtask

    initial begin
        logic [3:0] rl;

        // Reset + config + two-requester round-robin sequence.
        tbl[0]  = '{1'b1, 4'b0000, 32'h0,         4'b0000, 1'b0, mk(0, 12'h000, 32'h0,   4'h0, 4'h0, 0, 0, 0)};
        tbl[1]  = '{1'b0, 4'b0000, 32'h0,         4'b0000, 1'b0, mk(1, 12'h000, 32'h364, 4'h0, 4'h0, 0, 0, 0)};
        tbl[2]  = '{1'b0, 4'b0101, 32'h00B1_00A1, 4'b0000, 1'b0, mk(1, 12'h004, 32'h3,   4'h0, 4'h0, 0, 0, 0)};
        tbl[3]  = '{1'b0, 4'b0101, 32'h00B1_00A1, 4'b0000, 1'b0, mk(0, 12'h000, 32'h0,   4'h0, 4'h0, 1, 0, 0)};
        tbl[4]  = '{1'b0, 4'b0101, 32'h00B1_00A1, 4'b0000, 1'b0, mk(1, 12'h008, 32'hA1,  4'h1, 4'h1, 1, 1, 0)};
        tbl[5]  = '{1'b0, 4'b0101, 32'h00B1_00A2, 4'b0001, 1'b0, mk(1, 12'h008, 32'hA2,  4'h1, 4'h1, 1, 1, 0)};
        tbl[6]  = '{1'b0, 4'b0101, 32'h00B1_00C1, 4'b0101, 1'b0, mk(0, 12'h000, 32'h0,   4'h0, 4'h0, 1, 0, 0)};
        tbl[7]  = '{1'b0, 4'b0101, 32'h00B1_00C1, 4'b0101, 1'b0, mk(1, 12'h008, 32'hB1,  4'h4, 4'h4, 1, 1, 0)};
        tbl[8]  = '{1'b0, 4'b0001, 32'h0000_00C1, 4'b0001, 1'b0, mk(0, 12'h000, 32'h0,   4'h0, 4'h0, 1, 0, 0)};
        tbl[9]  = '{1'b0, 4'b0001, 32'h0000_00C1, 4'b0001, 1'b0, mk(1, 12'h008, 32'hC1,  4'h1, 4'h1, 1, 1, 0)};
        tbl[10] = '{1'b0, 4'b0000, 32'h0,         4'b0000, 1'b0, mk(0, 12'h000, 32'h0,   4'h0, 4'h0, 1, 0, 0)};

        rst = 1'b1; req_valid = '0; req_data = '0; req_last = '0; tx_full = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        model_reset();

        for (int i = 0; i < 11; i++) begin
            cycle(tbl[i].rst, tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].f, 1'b1, tbl[i].e,
                  $sformatf("tbl%0d", i));
        end

        // TX FIFO full for 5 cycles mid-packet (req1).
        cycle(0, 4'b0010, 32'h0000_1100, 4'b0000, 0, 0, '0, "full_arb");
        cycle(0, 4'b0010, 32'h0000_1100, 4'b0000, 0, 0, '0, "full_b0");
        repeat (5) cycle(0, 4'b0010, 32'h0000_2200, 4'b0000, 1, 0, '0, "full_stall");
        cycle(0, 4'b0010, 32'h0000_2200, 4'b0010, 0, 0, '0, "full_resume");

        // Owner req3 goes quiet; req0 waits. Stall clears on a byte and
        // freezes while full; abort lands after 255 idle cycles total.
        cycle(0, 4'b1000, 32'h3300_0000, 4'b0000, 0, 0, '0, "tmo_arb");
        cycle(0, 4'b1000, 32'h3300_0000, 4'b0000, 0, 0, '0, "tmo_b0");
        repeat (100) cycle(0, 4'b0001, 32'h0000_0044, 4'b0001, 0, 0, '0, "tmo_idle_a");
        cycle(0, 4'b1001, 32'h3400_0044, 4'b0001, 0, 0, '0, "tmo_b1");
        repeat (200) cycle(0, 4'b0001, 32'h0000_0044, 4'b0001, 0, 0, '0, "tmo_idle_b");
        repeat (10)  cycle(0, 4'b0001, 32'h0000_0044, 4'b0001, 1, 0, '0, "tmo_full");
        repeat (55)  cycle(0, 4'b0001, 32'h0000_0044, 4'b0001, 0, 0, '0, "tmo_idle_c");
        cycle(0, 4'b0001, 32'h0000_0044, 4'b0001, 0, 0, '0, "tmo_abort");
        cycle(0, 4'b0001, 32'h0000_0044, 4'b0001, 0, 0, '0, "tmo_next");

        // Reset in the middle of a packet.
        cycle(0, 4'b0010, 32'h0000_5500, 4'b0000, 0, 0, '0, "rst_arb");
        cycle(0, 4'b0010, 32'h0000_5500, 4'b0000, 0, 0, '0, "rst_b0");
        repeat (2) cycle(1, 4'b0010, 32'h0000_5600, 4'b0000, 0, 0, '0, "rst_hold");
        repeat (5) cycle(0, 4'b0010, 32'h0000_5600, 4'b0010, 0, 0, '0, "rst_recfg");

        // Randomized traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            for (int k = 0; k < N; k++) rl[k] = ($urandom_range(0, 3) == 0);
            cycle(($urandom_range(0, 299) == 0), 4'($urandom_range(0, 15)), $urandom,
                  rl, ($urandom_range(0, 4) == 0), 0, '0, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
